// File: rtl/regfile.sv
// Multi-port 32x32 register file with a hardwired zero register and combinational reads.
// Define REGFILE_WRITE_BYPASS_EN to forward same-cycle write data to matching read ports.
module regfile #(
  parameter int READ_PORTS  = 2,
  parameter int WRITE_PORTS = 1
) (
  input  logic                         clk,
  input  logic                         rst_n,
  input  logic [WRITE_PORTS-1:0]       we_i,
  input  logic [WRITE_PORTS-1:0][4:0]  waddr_i,
  input  logic [WRITE_PORTS-1:0][31:0] wrdata_i,
  input  logic [READ_PORTS-1:0][4:0]   raddr_i,
  output logic [READ_PORTS-1:0][31:0]  rddata_o
);

  logic [31:0] regs_reg [32];
  logic [31:1] wr_hit_next;
  logic [31:0] wr_data_next [1:31];

  // Later ports overwrite earlier ones, so the highest enabled port wins a conflict.
  always_comb begin
    wr_hit_next = '0;
    for (int r = 1; r < 32; r++) begin
      wr_data_next[r] = regs_reg[r];
      for (int j = 0; j < WRITE_PORTS; j++) begin
        if (we_i[j] && (waddr_i[j] == r[4:0])) begin
          wr_hit_next[r]  = 1'b1;
          wr_data_next[r] = wrdata_i[j];
        end
      end
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int r = 0; r < 32; r++) begin
        regs_reg[r] <= '0;
      end
    end else begin
      for (int r = 1; r < 32; r++) begin
        if (wr_hit_next[r]) begin
          regs_reg[r] <= wr_data_next[r];
        end
      end
    end
  end

  for (genvar gi = 0; gi < READ_PORTS; gi++) begin : g_rd
    logic [31:0] rd_data_next;

    always_comb begin
      rd_data_next = regs_reg[raddr_i[gi]];
`ifdef REGFILE_WRITE_BYPASS_EN
      for (int j = 0; j < WRITE_PORTS; j++) begin
        if (we_i[j] && (waddr_i[j] == raddr_i[gi])) begin
          rd_data_next = wrdata_i[j];
        end
      end
`endif
      // Index 0 and the reset window always read zero, whatever the array holds.
      if (!rst_n || (raddr_i[gi] == 5'd0)) begin
        rd_data_next = '0;
      end
    end

    assign rddata_o[gi] = rd_data_next;
  end

endmodule

// File: tb/tb_regfile.sv
// Scoreboard bench for regfile: directed scenarios plus a randomized run against a shadow model.
module tb_regfile;
  localparam int RP = 2;
  localparam int WP = 2;
`ifdef REGFILE_WRITE_BYPASS_EN
  localparam bit BYPASS = 1'b1;
`else
  localparam bit BYPASS = 1'b0;
`endif

  logic                 clk = 1'b0;
  logic                 rst_n;
  logic [WP-1:0]        we;
  logic [WP-1:0][4:0]   waddr;
  logic [WP-1:0][31:0]  wdata;
  logic [RP-1:0][4:0]   raddr;
  logic [RP-1:0][31:0]  rdata;

  logic [31:0] model [32];
  logic [31:0] exp_q [$];
  int errors = 0;
  int checks = 0;

  regfile #(.READ_PORTS(RP), .WRITE_PORTS(WP)) dut (
    .clk      (clk),
    .rst_n    (rst_n),
    .we_i     (we),
    .waddr_i  (waddr),
    .wrdata_i (wdata),
    .raddr_i  (raddr),
    .rddata_o (rdata)
  );

  always #5 clk = ~clk;

  function automatic logic [31:0] exp_read(input logic [4:0] a);
    logic [31:0] v;
    if (a == 5'd0 || rst_n !== 1'b1) return 32'h0;
    v = model[a];
    if (BYPASS) begin
      for (int j = 0; j < WP; j++) begin
        if (we[j] && waddr[j] == a) v = wdata[j];
      end
    end
    return v;
  endfunction

  task automatic test_reset();
    logic [31:0] e;
    #12;
    exp_q.push_back(32'h0);
    exp_q.push_back(32'h0);
    for (int p = 0; p < RP; p++) begin
      e = exp_q.pop_front();
      checks++;
      if (rdata[p] !== e) begin
        errors++;
        $display("FAIL reset port%0d got=%h exp=%h", p, rdata[p], e);
      end else $display("reset port%0d raddr=%0d data=%h", p, raddr[p], rdata[p]);
    end
    @(negedge clk);
    rst_n = 1'b1;
  endtask

  task automatic test_basic();
    logic [31:0] e;
    @(negedge clk);
    we = 2'b01; waddr[0] = 5'd3; wdata[0] = 32'h12345678;
    raddr[0] = 5'd3; raddr[1] = 5'd3;
    #1;
    exp_q.push_back(BYPASS ? 32'h12345678 : 32'h0);
    exp_q.push_back(BYPASS ? 32'h12345678 : 32'h0);
    for (int p = 0; p < RP; p++) begin
      e = exp_q.pop_front();
      checks++;
      if (rdata[p] !== e) begin
        errors++;
        $display("FAIL basic_same port%0d got=%h exp=%h", p, rdata[p], e);
      end else $display("basic_same port%0d data=%h", p, rdata[p]);
    end
    @(negedge clk);
    we = 2'b00;
    #1;
    exp_q.push_back(32'h12345678);
    exp_q.push_back(32'h12345678);
    for (int p = 0; p < RP; p++) begin
      e = exp_q.pop_front();
      checks++;
      if (rdata[p] !== e) begin
        errors++;
        $display("FAIL basic_next port%0d got=%h exp=%h", p, rdata[p], e);
      end else $display("basic_next port%0d data=%h", p, rdata[p]);
    end
  endtask

  task automatic test_zero();
    logic [31:0] e;
    @(negedge clk);
    we = 2'b11; waddr[0] = 5'd0; waddr[1] = 5'd0;
    wdata[0] = 32'hFFFFFFFF; wdata[1] = 32'hFFFFFFFF;
    raddr[0] = 5'd0; raddr[1] = 5'd0;
    #1;
    exp_q.push_back(32'h0);
    exp_q.push_back(32'h0);
    for (int p = 0; p < RP; p++) begin
      e = exp_q.pop_front();
      checks++;
      if (rdata[p] !== e) begin
        errors++;
        $display("FAIL zero_same port%0d got=%h exp=%h", p, rdata[p], e);
      end else $display("zero_same port%0d data=%h", p, rdata[p]);
    end
    @(negedge clk);
    we = 2'b00;
    #1;
    exp_q.push_back(32'h0);
    exp_q.push_back(32'h0);
    for (int p = 0; p < RP; p++) begin
      e = exp_q.pop_front();
      checks++;
      if (rdata[p] !== e) begin
        errors++;
        $display("FAIL zero_next port%0d got=%h exp=%h", p, rdata[p], e);
      end else $display("zero_next port%0d data=%h", p, rdata[p]);
    end
  endtask

  task automatic test_conflict();
    logic [31:0] e;
    @(negedge clk);
    we = 2'b11; waddr[0] = 5'd7; waddr[1] = 5'd7;
    wdata[0] = 32'h1; wdata[1] = 32'h2;
    raddr[0] = 5'd7; raddr[1] = 5'd7;
    #1;
    exp_q.push_back(BYPASS ? 32'h2 : 32'h0);
    exp_q.push_back(BYPASS ? 32'h2 : 32'h0);
    for (int p = 0; p < RP; p++) begin
      e = exp_q.pop_front();
      checks++;
      if (rdata[p] !== e) begin
        errors++;
        $display("FAIL conflict_same port%0d got=%h exp=%h", p, rdata[p], e);
      end else $display("conflict_same port%0d data=%h", p, rdata[p]);
    end
    @(negedge clk);
    we = 2'b00;
    #1;
    exp_q.push_back(32'h2);
    exp_q.push_back(32'h2);
    for (int p = 0; p < RP; p++) begin
      e = exp_q.pop_front();
      checks++;
      if (rdata[p] !== e) begin
        errors++;
        $display("FAIL conflict_next port%0d got=%h exp=%h", p, rdata[p], e);
      end else $display("conflict_next port%0d data=%h", p, rdata[p]);
    end
  endtask

  task automatic test_dual_write();
    logic [31:0] e;
    @(negedge clk);
    we = 2'b11; waddr[0] = 5'd1; waddr[1] = 5'd2;
    wdata[0] = 32'hA; wdata[1] = 32'hB;
    raddr[0] = 5'd1; raddr[1] = 5'd2;
    #1;
    exp_q.push_back(BYPASS ? 32'hA : 32'h0);
    exp_q.push_back(BYPASS ? 32'hB : 32'h0);
    for (int p = 0; p < RP; p++) begin
      e = exp_q.pop_front();
      checks++;
      if (rdata[p] !== e) begin
        errors++;
        $display("FAIL dual_same port%0d got=%h exp=%h", p, rdata[p], e);
      end else $display("dual_same port%0d data=%h", p, rdata[p]);
    end
    @(negedge clk);
    we = 2'b00;
    #1;
    exp_q.push_back(32'hA);
    exp_q.push_back(32'hB);
    for (int p = 0; p < RP; p++) begin
      e = exp_q.pop_front();
      checks++;
      if (rdata[p] !== e) begin
        errors++;
        $display("FAIL dual_next port%0d got=%h exp=%h", p, rdata[p], e);
      end else $display("dual_next port%0d data=%h", p, rdata[p]);
    end
  endtask

  task automatic test_async_reset();
    logic [31:0] e;
    @(negedge clk);
    we = 2'b01; waddr[0] = 5'd5; wdata[0] = 32'hDEADBEEF;
    raddr[0] = 5'd5; raddr[1] = 5'd3;
    @(negedge clk);
    we = 2'b00;
    #1;
    exp_q.push_back(32'hDEADBEEF);
    exp_q.push_back(32'h12345678);
    for (int p = 0; p < RP; p++) begin
      e = exp_q.pop_front();
      checks++;
      if (rdata[p] !== e) begin
        errors++;
        $display("FAIL areset_pre port%0d got=%h exp=%h", p, rdata[p], e);
      end else $display("areset_pre port%0d data=%h", p, rdata[p]);
    end
    #1;
    rst_n = 1'b0;
    #1;
    exp_q.push_back(32'h0);
    exp_q.push_back(32'h0);
    for (int p = 0; p < RP; p++) begin
      e = exp_q.pop_front();
      checks++;
      if (rdata[p] !== e) begin
        errors++;
        $display("FAIL areset_now port%0d got=%h exp=%h", p, rdata[p], e);
      end else $display("areset_now port%0d data=%h", p, rdata[p]);
    end
    @(negedge clk);
    rst_n = 1'b1;
    #1;
    exp_q.push_back(32'h0);
    exp_q.push_back(32'h0);
    for (int p = 0; p < RP; p++) begin
      e = exp_q.pop_front();
      checks++;
      if (rdata[p] !== e) begin
        errors++;
        $display("FAIL areset_post port%0d got=%h exp=%h", p, rdata[p], e);
      end else $display("areset_post port%0d data=%h", p, rdata[p]);
    end
  endtask

  task automatic test_reset_edge();
    logic [31:0] e;
    @(negedge clk);
    we = 2'b01; waddr[0] = 5'd9; wdata[0] = 32'h55;
    raddr[0] = 5'd9; raddr[1] = 5'd9;
    @(posedge clk);
    rst_n = 1'b0;
    #1;
    exp_q.push_back(32'h0);
    exp_q.push_back(32'h0);
    for (int p = 0; p < RP; p++) begin
      e = exp_q.pop_front();
      checks++;
      if (rdata[p] !== e) begin
        errors++;
        $display("FAIL redge_in_reset port%0d got=%h exp=%h", p, rdata[p], e);
      end else $display("redge_in_reset port%0d data=%h", p, rdata[p]);
    end
    @(negedge clk);
    rst_n = 1'b1;
    wdata[0] = 32'h66;
    #1;
    exp_q.push_back(BYPASS ? 32'h66 : 32'h0);
    exp_q.push_back(BYPASS ? 32'h66 : 32'h0);
    for (int p = 0; p < RP; p++) begin
      e = exp_q.pop_front();
      checks++;
      if (rdata[p] !== e) begin
        errors++;
        $display("FAIL redge_release port%0d got=%h exp=%h", p, rdata[p], e);
      end else $display("redge_release port%0d data=%h", p, rdata[p]);
    end
    @(negedge clk);
    we = 2'b00;
    #1;
    exp_q.push_back(32'h66);
    exp_q.push_back(32'h66);
    for (int p = 0; p < RP; p++) begin
      e = exp_q.pop_front();
      checks++;
      if (rdata[p] !== e) begin
        errors++;
        $display("FAIL redge_first_write port%0d got=%h exp=%h", p, rdata[p], e);
      end else $display("redge_first_write port%0d data=%h", p, rdata[p]);
    end
  endtask

  task automatic test_random();
    logic [31:0] e;
    @(negedge clk);
    we = 2'b00;
    rst_n = 1'b0;
    for (int r = 0; r < 32; r++) model[r] = 32'h0;
    #1;
    rst_n = 1'b1;
    for (int n = 0; n < 120; n++) begin
      @(negedge clk);
      we = 2'($urandom_range(0, 3));
      for (int j = 0; j < WP; j++) begin
        waddr[j] = 5'($urandom_range(0, 7));
        wdata[j] = $urandom;
      end
      for (int p = 0; p < RP; p++) raddr[p] = 5'($urandom_range(0, 7));
      #1;
      for (int p = 0; p < RP; p++) exp_q.push_back(exp_read(raddr[p]));
      for (int p = 0; p < RP; p++) begin
        e = exp_q.pop_front();
        checks++;
        if (rdata[p] !== e) begin
          errors++;
          $display("FAIL random%0d port%0d raddr=%0d got=%h exp=%h", n, p, raddr[p], rdata[p], e);
        end else $display("random%0d port%0d raddr=%0d data=%h", n, p, raddr[p], rdata[p]);
      end
      for (int j = 0; j < WP; j++) begin
        if (we[j] && waddr[j] != 5'd0) model[waddr[j]] = wdata[j];
      end
    end
    @(negedge clk);
    we = 2'b00;
  endtask

  initial begin
    rst_n = 1'b0;
    we = '0;
    waddr = '0;
    wdata = '0;
    raddr[0] = 5'd5;
    raddr[1] = 5'd31;
    test_reset();
    test_basic();
    test_zero();
    test_conflict();
    test_dual_write();
    test_async_reset();
    test_reset_edge();
    test_random();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
